// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider: O_CLK is low for P-H cycles then high for H cycles.
// New P/H values are staged and only take effect at a period boundary (or while idle).
module prog_clk_divider #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEFAULT_DIV  = 20,
    parameter int unsigned DEFAULT_HIGH = 10
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             load_ack,
    output logic             cfg_err,
    output logic             O_CLK,
    output logic             tick
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] stage_div;
    logic [WIDTH-1:0] stage_high;
    logic             pending;

    logic             load_valid;
    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0] high_nxt;
    logic             clk_nxt;

    // high_q < div_q always holds, so div_nxt - high_nxt never wraps below zero
    always_comb begin
        load_valid = (div_in >= WIDTH'(2)) && (high_in >= WIDTH'(1)) && (high_in < div_in);
        wrap       = (cnt == div_q - WIDTH'(1));
        apply      = pending && ((state == IDLE) || (en && wrap));
        div_nxt    = apply ? stage_div  : div_q;
        high_nxt   = apply ? stage_high : high_q;
        cnt_nxt    = wrap ? '0 : cnt + WIDTH'(1);
        clk_nxt    = (cnt_nxt >= div_nxt - high_nxt);
    end

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            div_q      <= WIDTH'(DEFAULT_DIV);
            high_q     <= WIDTH'(DEFAULT_HIGH);
            stage_div  <= '0;
            stage_high <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            cfg_err    <= 1'b0;
            O_CLK      <= 1'b0;
            tick       <= 1'b0;
        end else begin
            load_ack <= apply;
            cfg_err  <= load && !load_valid;
            div_q    <= div_nxt;
            high_q   <= high_nxt;

            // A load landing on the apply edge re-arms pending for the next boundary
            if (load && load_valid) begin
                stage_div  <= div_in;
                stage_high <= high_in;
                pending    <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end

            if (state == IDLE) begin
                cnt   <= '0;
                O_CLK <= 1'b0;
                tick  <= 1'b0;
                if (en) begin
                    state <= RUN;
                end
            end else if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                O_CLK <= 1'b0;
                tick  <= 1'b0;
            end else begin
                cnt   <= cnt_nxt;
                O_CLK <= clk_nxt;
                tick  <= clk_nxt & ~O_CLK;
            end
        end
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: scoreboard of per-cycle expected outputs from a phase model,
// a table of load-validation vectors, and hand-written multi-cycle corner sequences.
module tb_prog_clk_divider;

    logic        I_CLK = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] div_in;
    logic [31:0] high_in;
    logic        load_ack;
    logic        cfg_err;
    logic        O_CLK;
    logic        tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic o;
        logic tk;
        logic ack;
        logic err;
    } exp_t;

    typedef struct {
        logic [31:0] div;
        logic [31:0] high;
        logic        exp_err;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    // Reference model: phase within the current period plus active/staged configuration
    logic        m_run;
    logic [31:0] m_phase;
    logic [31:0] m_p;
    logic [31:0] m_h;
    logic [31:0] m_sp;
    logic [31:0] m_sh;
    logic        m_pend;
    logic        m_o;

    prog_clk_divider #(.WIDTH(32), .DEFAULT_DIV(20), .DEFAULT_HIGH(10)) dut (
        .I_CLK    (I_CLK),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .div_in   (div_in),
        .high_in  (high_in),
        .load_ack (load_ack),
        .cfg_err  (cfg_err),
        .O_CLK    (O_CLK),
        .tick     (tick)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_phase = '0;
        m_p     = 32'd20;
        m_h     = 32'd10;
        m_sp    = '0;
        m_sh    = '0;
        m_pend  = 1'b0;
        m_o     = 1'b0;
        sbq.delete();
    endtask

    task automatic model_step();
        logic v;
        logic applied;
        exp_t e;
        v       = (div_in >= 32'd2) && (high_in >= 32'd1) && (high_in < div_in);
        applied = 1'b0;
        e.err   = load && !v;
        e.tk    = 1'b0;
        if (!m_run) begin
            if (m_pend) begin
                m_p = m_sp;
                m_h = m_sh;
                applied = 1'b1;
            end
            m_run   = en;
            m_phase = '0;
            m_o     = 1'b0;
        end else if (!en) begin
            m_run   = 1'b0;
            m_phase = '0;
            m_o     = 1'b0;
        end else begin
            if (m_phase == m_p - 32'd1) begin
                m_phase = '0;
                if (m_pend) begin
                    m_p = m_sp;
                    m_h = m_sh;
                    applied = 1'b1;
                end
            end else begin
                m_phase = m_phase + 32'd1;
            end
            e.tk = (m_phase == m_p - m_h);
            m_o  = (m_phase >= m_p - m_h);
        end
        if (applied) m_pend = 1'b0;
        if (load && v) begin
            m_sp   = div_in;
            m_sh   = high_in;
            m_pend = 1'b1;
        end
        e.o   = m_o;
        e.ack = applied;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            check_bit("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sbq.pop_front();
            check_bit("sb_O_CLK", O_CLK, e.o);
            check_bit("sb_tick", tick, e.tk);
            check_bit("sb_load_ack", load_ack, e.ack);
            check_bit("sb_cfg_err", cfg_err, e.err);
        end
    endtask

    // One clock: predict, let the edge happen, compare 1 time unit later
    task automatic applyStimulus();
        model_step();
        @(posedge I_CLK);
        #1;
        checkOutput();
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        div_in  = '0;
        high_in = '0;
        model_reset();
        repeat (2) @(posedge I_CLK);
        #1;
        check_bit("reset_O_CLK", O_CLK, 1'b0);
        check_bit("reset_tick", tick, 1'b0);
        check_bit("reset_load_ack", load_ack, 1'b0);
        check_bit("reset_cfg_err", cfg_err, 1'b0);
        rst = 1'b0;
    endtask

    task automatic single_load(input logic [31:0] d, input logic [31:0] h);
        load    = 1'b1;
        div_in  = d;
        high_in = h;
        applyStimulus();
        load = 1'b0;
    endtask

    initial begin
        int last_tick;
        int cnt;
        int acks;
        logic [9:0]  pat2;
        logic [11:0] pat4;

        vecs[0] = '{32'd1, 32'd1, 1'b1};
        vecs[1] = '{32'd5, 32'd0, 1'b1};
        vecs[2] = '{32'd5, 32'd5, 1'b1};
        vecs[3] = '{32'd0, 32'd0, 1'b1};
        vecs[4] = '{32'd6, 32'd7, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[6] = '{32'd2, 32'd1, 1'b0};
        vecs[7] = '{32'd7, 32'd3, 1'b0};

        reset_dut();

        // Defaults: 10 low / 10 high, one tick every 20 cycles
        en = 1'b1;
        last_tick = -1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus();
            if (tick === 1'b1) begin
                if (last_tick >= 0) check_val("t1_tick_gap", i - last_tick, 20);
                last_tick = i;
            end
        end

        // Load 5/2 while cnt==7: the 20-cycle period completes before it applies
        for (int i = 0; i < 40 && m_phase != 32'd7; i++) applyStimulus();
        single_load(32'd5, 32'd2);
        cnt = 1;
        while (load_ack !== 1'b1 && cnt < 30) begin
            applyStimulus();
            cnt++;
        end
        check_val("t2_ack_latency", cnt, 13);
        pat2 = 10'b0011000110;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            check_bit("t2_pattern", O_CLK, pat2[9-i]);
        end

        // Two loads in one period: last wins, single ack, then 3 low / 3 high
        for (int i = 0; i < 10 && m_phase != 32'd0; i++) applyStimulus();
        single_load(32'd8, 32'd4);
        single_load(32'd6, 32'd3);
        acks = 0;
        cnt = 0;
        while (load_ack !== 1'b1 && cnt < 10) begin
            applyStimulus();
            cnt++;
        end
        if (load_ack === 1'b1) acks++;
        pat4 = 12'b001110001110;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (load_ack === 1'b1) acks++;
            check_bit("t4_pattern", O_CLK, pat4[11-i]);
        end
        check_val("t4_ack_count", acks, 1);

        // Minimum ratio 2/1: O_CLK toggles every cycle, tick on every high
        for (int i = 0; i < 10 && m_phase != 32'd0; i++) applyStimulus();
        single_load(32'd2, 32'd1);
        cnt = 0;
        while (load_ack !== 1'b1 && cnt < 10) begin
            applyStimulus();
            cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            check_bit("t5_toggle", O_CLK, (i % 2 == 0));
            check_bit("t5_tick", tick, (i % 2 == 0));
        end

        // Validation table, applied while idle so valid entries take effect immediately
        en = 1'b0;
        applyStimulus();
        foreach (vecs[k]) begin
            single_load(vecs[k].div, vecs[k].high);
            check_bit("t3_cfg_err", cfg_err, vecs[k].exp_err);
            applyStimulus();
            check_bit("t3_load_ack", load_ack, !vecs[k].exp_err);
        end
        en = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus();

        // Async reset mid-high with a pending config: outputs drop without a clock edge
        for (int i = 0; i < 20 && m_o != 1'b1; i++) applyStimulus();
        single_load(32'd4, 32'd2);
        check_bit("t6_high_before_reset", O_CLK, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_bit("t6_async_O_CLK", O_CLK, 1'b0);
        check_bit("t6_async_tick", tick, 1'b0);
        check_bit("t6_async_load_ack", load_ack, 1'b0);
        model_reset();
        @(posedge I_CLK);
        #1;
        rst = 1'b0;
        acks = 0;
        last_tick = -1;
        for (int i = 0; i < 45; i++) begin
            applyStimulus();
            if (load_ack === 1'b1) acks++;
            if (tick === 1'b1) begin
                if (last_tick >= 0) check_val("t6_default_period", i - last_tick, 20);
                last_tick = i;
            end
        end
        check_val("t6_no_ack", acks, 0);

        // en dropped mid-high, then a fresh period starting low on re-entry
        for (int i = 0; i < 25 && m_phase != 32'd14; i++) applyStimulus();
        en = 1'b0;
        applyStimulus();
        check_bit("t7_drop_low", O_CLK, 1'b0);
        applyStimulus();
        applyStimulus();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            check_bit("t7_fresh_period", O_CLK, (i >= 10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
